chan_mux_rr: RTL and testbench
==============================

Name: chan_mux_rr

Overview:
- Parametrised N-channel, W-bit multiplexer. Successor to the fixed 2/4/8-input single-bit gate-level muxes.
- Adds a registered output stage, per-channel valid/ready handshakes, and two modes:
  - static select (mode=0), equivalent to the classic mux;
  - round-robin fair scanning (mode=1).
- Sits between multiple producer channels and one consumer stream.

Parameters:
- N, 8: number of input channels (2..16).
- W, 8: data width per channel.
- SELW, 3: select/index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = static select via sel; 1 = round-robin scan.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  N*W  flattened inputs; channel k occupies bits [k*W+W-1 : k*W].
- in_valid  input  N  per-channel data-valid.
- in_ready  output  N  per-channel accept, one-hot or zero, combinational.
- out_data  output  W  registered selected data.
- out_sel  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high. It is sampled on the rising edge of clk and takes priority over all other activity.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is 0 throughout any cycle in which rst=1.
- Output register load enable: load_en = ~out_valid | out_ready. The register refills in the same cycle it drains, so back-to-back throughput is 1 word/cycle.
- Grant, mode=0:
  - grant = sel, provided sel < N and in_valid[sel] = 1.
  - Otherwise there is no grant. sel >= N always gives no grant.
  - ptr is unchanged in this mode.
- Grant, mode=1:
  - grant = the first k with in_valid[k] = 1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - If no channel is valid, there is no grant.
- Handshake:
  - in_ready[grant] = load_en when a grant exists; all other in_ready bits are 0.
  - A transfer on channel k occurs when in_valid[k] & in_ready[k].
- On a transfer, at the next edge:
  - out_data <= in_data[k]
  - out_sel <= k
  - out_valid <= 1
  - if mode=1: ptr <= (k == N-1) ? 0 : k+1
- Latency: data appears on out_data 1 cycle after the input transfer.
- Drain without refill: if out_valid & out_ready and there is no transfer, then out_valid <= 0. out_data and out_sel hold their last values.
- Stall: if out_valid=1 and out_ready=0, all in_ready bits are 0 and the output register holds.
- Fairness: in mode=1, a continuously valid channel waits at most N-1 grants.
- Mode switch: takes effect on the grant evaluated in the same cycle (mode is combinational into grant). ptr retains its value across mode=0 periods. A word already in the output register is unaffected.
- in_valid may deassert without a transfer; there is no obligation on producers.
- Reset mid-operation: a pending output word is discarded (out_valid=0). No transfer occurs in the reset cycle.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0; first grant after release is channel 0 in mode=1.
- Static mode: N=8, mode=0, sel=5, in_data[5]=8'hA5, in_valid=8'hFF, out_ready=1 -> in_ready=8'h20 every cycle; out_data=A5, out_sel=5 one cycle later; continuous out_valid.
- Round-robin wrap: mode=1, in_valid=8'b1000_0101, out_ready=1 -> grant sequence 0, 2, 7, 0, 2, 7; out_sel follows one cycle later; ptr wraps 7->0.
- Backpressure: mode=1, out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data stable; on out_ready=1, refill occurs the same cycle and no word is lost or duplicated (scoreboard check).
- Invalid select / idle: mode=0, sel=5, in_valid[5]=0 (others 1) -> no transfer; out_valid drops after the existing word drains. Same with N=6 and sel=7 -> no grant.
- Mode switch and mid-stream reset: run mode=1 until ptr=3, switch to mode=0 with sel=1, then back to mode=1 -> next RR grant searches from 3. Assert rst while out_valid=1 -> out_valid=0 next edge and ptr=0.

Source files
------------

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-way W-bit mux (static select or round-robin) into one registered output word.
// Latency 1 cycle; a full output register that is not being read (out_valid & ~out_ready) holds every in_ready low.
module chan_mux_rr #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready
);
    logic            load_en;
    logic            xfer;
    logic [SELW-1:0] ptr;
    logic            grant_vld;
    logic [SELW-1:0] grant;
    logic [W-1:0]    grant_dat;
    logic            hi_vld;
    logic            lo_vld;
    logic [SELW-1:0] hi_idx;
    logic [SELW-1:0] lo_idx;

    assign load_en = ~out_valid | out_ready;
    assign xfer    = grant_vld & load_en & ~rst;

    // Lowest valid index at/after ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_vld = 1'b1;
                lo_idx = SELW'(k);
                if (k >= int'(ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = SELW'(k);
                end
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (mode) begin
            if (hi_vld) begin
                grant_vld = 1'b1;
                grant     = hi_idx;
            end else if (lo_vld) begin
                grant_vld = 1'b1;
                grant     = lo_idx;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant     = sel;
                end
            end
        end
    end

    always_comb begin
        in_ready  = '0;
        grant_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SELW'(k)) begin
                in_ready[k] = xfer;
                grant_dat   = in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_dat;
                out_sel   <= grant;
                if (mode) begin
                    ptr <= (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_chan_mux_rr.sv
// Bench for chan_mux_rr: vector table with hand-derived in_ready, plus scoreboard queues for output words.
module tb_chan_mux_rr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [2:0]  sel = '0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_valid = '0;
    logic [7:0]  in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  in_ready6;
    logic [7:0]  out_data6;
    logic [2:0]  out_sel6;
    logic        out_valid6;

    always #5 clk = ~clk;

    chan_mux_rr #(.N(8), .W(8), .SELW(3)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    chan_mux_rr #(.N(6), .W(8), .SELW(3)) dut6 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data[47:0]), .in_valid(in_valid[5:0]), .in_ready(in_ready6),
        .out_data(out_data6), .out_sel(out_sel6), .out_valid(out_valid6),
        .out_ready(out_ready)
    );

    typedef struct {
        bit         pre_rst;
        bit         mode;
        logic [2:0] sel;
        logic [7:0] vld;
        bit         ordy;
        logic [7:0] exp_rdy;
        bit         chk6;
        logic [5:0] exp_rdy6;
        string      name;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    sb_t  sbq6[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   miscompares = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] dat_prev = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit pr, bit m, logic [2:0] s, logic [7:0] v, bit o,
                                logic [7:0] er, bit c6, logic [5:0] er6, string nm);
        vec_t r;
        r.pre_rst = pr; r.mode = m; r.sel = s; r.vld = v; r.ordy = o;
        r.exp_rdy = er; r.chk6 = c6; r.exp_rdy6 = er6; r.name = nm;
        return r;
    endfunction

    // Entered just after a posedge; leaves at the next posedge.
    task automatic do_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            rst = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_in_ready6", 32'(in_ready6), 32'h0);
            if (c == 1) begin
                chk("rst_out_valid", 32'(out_valid), 32'h0);
                chk("rst_out_data", 32'(out_data), 32'h0);
                chk("rst_out_sel", 32'(out_sel), 32'h0);
                chk("rst_out_valid6", 32'(out_valid6), 32'h0);
            end
            @(posedge clk);
        end
        sbq.delete();
        sbq6.delete();
        stall_prev = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        #1;
        rst = 1'b0; mode = v.mode; sel = v.sel; in_valid = v.vld; out_ready = v.ordy;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = {4'(k), 4'(n_vec)};
        n_vec++;
        @(negedge clk);
        chk({v.name, ".in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        chk({v.name, ".out_valid"}, 32'(out_valid), 32'(sbq.size() != 0));
        if (stall_prev && out_valid)
            chk({v.name, ".hold"}, 32'(out_data), 32'(dat_prev));
        if (out_valid && out_ready && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({v.name, ".out_data"}, 32'(out_data), 32'(e.d));
            chk({v.name, ".out_sel"}, 32'(out_sel), 32'(e.s));
        end
        stall_prev = out_valid & ~out_ready;
        dat_prev = out_data;
        for (int k = 0; k < 8; k++)
            if (v.exp_rdy[k]) sbq.push_back({in_data[k*8 +: 8], 3'(k)});
        if (v.chk6) begin
            chk({v.name, ".in_ready6"}, 32'(in_ready6), 32'(v.exp_rdy6));
            chk({v.name, ".out_valid6"}, 32'(out_valid6), 32'(sbq6.size() != 0));
            if (out_valid6 && out_ready && sbq6.size() != 0) begin
                e = sbq6.pop_front();
                chk({v.name, ".out_data6"}, 32'(out_data6), 32'(e.d));
                chk({v.name, ".out_sel6"}, 32'(out_sel6), 32'(e.s));
            end
            for (int k = 0; k < 6; k++)
                if (v.exp_rdy6[k]) sbq6.push_back({in_data[k*8 +: 8], 3'(k)});
        end
        @(posedge clk);
    endtask

    initial begin
        // First grant after reset, then round-robin over channels 0,2,7 (ptr starts at 1).
        vecs.push_back(mk(1, 1, 0, 8'hFF, 1, 8'h01, 0, 0, "rr_first"));
        vecs.push_back(mk(0, 1, 0, 8'h85, 1, 8'h04, 0, 0, "rr_a2"));
        vecs.push_back(mk(0, 1, 0, 8'h85, 1, 8'h80, 0, 0, "rr_a7"));
        vecs.push_back(mk(0, 1, 0, 8'h85, 1, 8'h01, 0, 0, "rr_wrap0"));
        vecs.push_back(mk(0, 1, 0, 8'h85, 1, 8'h04, 0, 0, "rr_b2"));
        vecs.push_back(mk(0, 1, 0, 8'h85, 1, 8'h80, 0, 0, "rr_b7"));
        vecs.push_back(mk(0, 1, 0, 8'h85, 1, 8'h01, 0, 0, "rr_wrap1"));
        vecs.push_back(mk(0, 0, 5, 8'hFF, 1, 8'h20, 0, 0, "static_a"));
        vecs.push_back(mk(0, 0, 5, 8'hFF, 1, 8'h20, 0, 0, "static_b"));
        vecs.push_back(mk(0, 0, 5, 8'hFF, 1, 8'h20, 0, 0, "static_c"));
        // Stall 3 cycles, then refill in the draining cycle (ptr is still 1).
        vecs.push_back(mk(0, 1, 0, 8'hFF, 0, 8'h00, 0, 0, "stall_a"));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 0, 8'h00, 0, 0, "stall_b"));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 0, 8'h00, 0, 0, "stall_c"));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 8'h02, 0, 0, "refill"));
        vecs.push_back(mk(0, 0, 5, 8'hDF, 1, 8'h00, 0, 0, "badsel_a"));
        vecs.push_back(mk(0, 0, 5, 8'hDF, 1, 8'h00, 0, 0, "badsel_b"));
        // Reach ptr=3, detour through static mode, resume scanning from 3.
        vecs.push_back(mk(0, 1, 0, 8'h04, 1, 8'h04, 0, 0, "to_ptr3"));
        vecs.push_back(mk(0, 0, 1, 8'hFF, 1, 8'h02, 0, 0, "sw_static_a"));
        vecs.push_back(mk(0, 0, 1, 8'hFF, 1, 8'h02, 0, 0, "sw_static_b"));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 8'h08, 0, 0, "sw_rr_3"));
        vecs.push_back(mk(0, 1, 0, 8'h03, 1, 8'h01, 0, 0, "sw_rr_wrap"));
        vecs.push_back(mk(0, 1, 0, 8'h03, 1, 8'h02, 0, 0, "sw_rr_1"));
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, "idle_a"));
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, "idle_b"));
        // Empty register accepts even with out_ready low; then it must stall.
        vecs.push_back(mk(0, 1, 0, 8'h10, 0, 8'h10, 0, 0, "empty_fill"));
        vecs.push_back(mk(0, 1, 0, 8'h10, 0, 8'h00, 0, 0, "full_stall"));
        vecs.push_back(mk(0, 1, 0, 8'h10, 1, 8'h10, 0, 0, "full_refill"));
        // Reset while a word is pending: word dropped, ptr back to 0.
        vecs.push_back(mk(1, 1, 0, 8'hFF, 1, 8'h01, 0, 0, "midrst_ptr0"));
        // N=6 copy: sel=7 is out of range, sel=5 works, sel=5 without valid idles.
        vecs.push_back(mk(1, 0, 7, 8'hFF, 1, 8'h80, 1, 6'h00, "n6_sel7_a"));
        vecs.push_back(mk(0, 0, 7, 8'hFF, 1, 8'h80, 1, 6'h00, "n6_sel7_b"));
        vecs.push_back(mk(0, 0, 5, 8'hFF, 1, 8'h20, 1, 6'h20, "n6_sel5_a"));
        vecs.push_back(mk(0, 0, 5, 8'hFF, 1, 8'h20, 1, 6'h20, "n6_sel5_b"));
        vecs.push_back(mk(0, 0, 5, 8'hDF, 1, 8'h00, 1, 6'h00, "n6_novld_a"));
        vecs.push_back(mk(0, 0, 5, 8'hDF, 1, 8'h00, 1, 6'h00, "n6_novld_b"));

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) do_reset();
            apply(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
